// File: rtl/bp_pkg.sv
// bp_pkg: counter encodings, BTB entry metadata and PC field extraction for branch_predictor.
// BRANCH_PRED_RAS_EN adds the per-entry is_ret bit.
package bp_pkg;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    // Tag and target live in their own arrays because their widths are module parameters.
    typedef struct packed {
        logic       valid;
        logic [1:0] ctr;
`ifdef BRANCH_PRED_RAS_EN
        logic       is_ret;
`endif
    } btb_meta_t;

    function automatic logic [63:0] bp_index(input logic [63:0] pc, input int idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] bp_tag(input logic [63:0] pc, input int idx_w, input int tag_w);
        return (pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1);
    endfunction

endpackage

// File: rtl/bp_ras.sv
// bp_ras: circular return-address stack; a push when full overwrites the oldest entry,
// a pop when empty is ignored. Pop is applied before push when both are requested.
module bp_ras #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [ADDR_W-1:0] top_o,
    output logic              empty_o
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] stk_q [1 << PW];
    logic [PW-1:0]     ptr_q, ptr_d, ptr_p;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_p;
    logic              pop_ok;

    always_comb begin
        pop_ok = pop_i && cnt_q != '0;
        ptr_p  = pop_ok ? ptr_q - PW'(1) : ptr_q;
        cnt_p  = cnt_q - CW'(pop_ok);
        ptr_d  = push_i ? ptr_p + PW'(1) : ptr_p;
        cnt_d  = (push_i && cnt_p != CW'(DEPTH)) ? cnt_p + CW'(1) : cnt_p;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push_i) stk_q[ptr_d] <= addr_i;
    end

    assign top_o   = stk_q[ptr_q];
    assign empty_o = cnt_q == '0;

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: tagged direct-mapped BTB with 2-bit counters, combinational lookup,
// registered ID updates. Optional return-address stack under BRANCH_PRED_RAS_EN.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES   = 64,
    parameter int TAG_W     = 8,
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_pc_i,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_mispred_i,
    input  logic              upd_is_call_i,
    input  logic              upd_is_ret_i,
    output logic [31:0]       mispred_cnt_o
);
    localparam int IDX_W = $clog2(ENTRIES);

    btb_meta_t         meta_q [ENTRIES];
    logic [TAG_W-1:0]  tag_q  [ENTRIES];
    logic [ADDR_W-1:0] tgt_q  [ENTRIES];
    logic [31:0]       mis_q, mis_d;
    logic [1:0]        ctr_d;
    logic [IDX_W-1:0]  lk_idx, up_idx;
    logic [TAG_W-1:0]  lk_tag, up_tag;
    btb_meta_t         lk_m, up_m;
    logic              lk_hit, up_hit, ras_use;
    logic [ADDR_W-1:0] ras_top;

    assign lk_idx = IDX_W'(bp_index(64'(if_pc_i), IDX_W));
    assign lk_tag = TAG_W'(bp_tag(64'(if_pc_i), IDX_W, TAG_W));
    assign up_idx = IDX_W'(bp_index(64'(upd_pc_i), IDX_W));
    assign up_tag = TAG_W'(bp_tag(64'(upd_pc_i), IDX_W, TAG_W));
    assign lk_m   = meta_q[lk_idx];
    assign up_m   = meta_q[up_idx];
    assign lk_hit = lk_m.valid && tag_q[lk_idx] == lk_tag;
    assign up_hit = up_m.valid && tag_q[up_idx] == up_tag;

`ifdef BRANCH_PRED_RAS_EN
    logic ras_empty;

    bp_ras #(.DEPTH(RAS_DEPTH), .ADDR_W(ADDR_W)) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push_i  (upd_valid_i && upd_is_call_i),
        .pop_i   (upd_valid_i && upd_is_ret_i),
        .addr_i  (upd_pc_i + ADDR_W'(8)),
        .top_o   (ras_top),
        .empty_o (ras_empty)
    );

    assign ras_use = lk_m.is_ret && !ras_empty;
`else
    logic unused_ras;

    assign unused_ras = ^{upd_is_call_i, upd_is_ret_i};
    assign ras_use    = 1'b0;
    assign ras_top    = '0;
`endif

    always_comb begin
        pred_hit_o    = rst && lk_hit;
        pred_taken_o  = pred_hit_o && (lk_m.ctr[1] || ras_use);
        pred_target_o = !pred_taken_o ? '0 : ras_use ? ras_top : tgt_q[lk_idx];
        ctr_d = upd_taken_i ? (up_m.ctr == CTR_ST ? CTR_ST : up_m.ctr + 2'd1)
                            : (up_m.ctr == CTR_SNT ? CTR_SNT : up_m.ctr - 2'd1);
        mis_d = (upd_valid_i && upd_mispred_i && mis_q != '1) ? mis_q + 32'd1 : mis_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                meta_q[i].valid <= 1'b0;
                meta_q[i].ctr   <= CTR_WNT;
`ifdef BRANCH_PRED_RAS_EN
                meta_q[i].is_ret <= 1'b0;
`endif
            end
            mis_q <= '0;
        end else begin
            mis_q <= mis_d;
            if (upd_valid_i && up_hit) begin
                meta_q[up_idx].ctr <= ctr_d;
`ifdef BRANCH_PRED_RAS_EN
                meta_q[up_idx].is_ret <= up_m.is_ret | upd_is_ret_i;
`endif
            end else if (upd_valid_i && upd_taken_i) begin
                meta_q[up_idx].valid <= 1'b1;
                meta_q[up_idx].ctr   <= CTR_WT;
`ifdef BRANCH_PRED_RAS_EN
                meta_q[up_idx].is_ret <= upd_is_ret_i;
`endif
            end
        end
    end

    // A taken update either allocates or already matches the tag, so tag and target share one write.
    always_ff @(posedge clk) begin
        if (rst && upd_valid_i && upd_taken_i) begin
            tag_q[up_idx] <= up_tag;
            tgt_q[up_idx] <= upd_target_i;
        end
    end

    assign mispred_cnt_o = mis_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: table-driven checks of branch_predictor with an expected-value queue;
// RAS sequences are included when BRANCH_PRED_RAS_EN is defined.
module tb_branch_predictor;

    typedef struct {
        string       name;
        logic        rn;
        logic [31:0] pc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        um;
        logic        uc;
        logic        ur;
        logic        eh;
        logic        et;
        logic [31:0] etgt;
        logic [31:0] emis;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] if_pc = '0;
    logic        hit, taken;
    logic [31:0] tgt;
    logic        uv = 1'b0, ut = 1'b0, um = 1'b0, uc = 1'b0, ur = 1'b0;
    logic [31:0] upc = '0, utgt = '0;
    logic [31:0] mis;

    int   checks = 0;
    int   errors = 0;
    vec_t exp_q [$];
    vec_t tbl   [$];

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk           (clk),
        .rst           (rst),
        .if_pc_i       (if_pc),
        .pred_hit_o    (hit),
        .pred_taken_o  (taken),
        .pred_target_o (tgt),
        .upd_valid_i   (uv),
        .upd_pc_i      (upc),
        .upd_taken_i   (ut),
        .upd_target_i  (utgt),
        .upd_mispred_i (um),
        .upd_is_call_i (uc),
        .upd_is_ret_i  (ur),
        .mispred_cnt_o (mis)
    );

    function automatic vec_t mk(input string name, input logic [31:0] pc, input logic v,
                                input logic [31:0] p, input logic t, input logic [31:0] g,
                                input logic m, input logic c, input logic r, input logic eh,
                                input logic et, input logic [31:0] etgt, input logic [31:0] emis,
                                input logic rn = 1'b1);
        vec_t x;
        x.name = name; x.rn = rn; x.pc = pc; x.uv = v; x.upc = p; x.ut = t; x.utgt = g;
        x.um = m; x.uc = c; x.ur = r; x.eh = eh; x.et = et; x.etgt = etgt; x.emis = emis;
        return x;
    endfunction

    // Inputs change at negedge; combinational lookup is sampled 2 time units later, well before posedge.
    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst = v.rn; if_pc = v.pc; uv = v.uv; upc = v.upc; ut = v.ut; utgt = v.utgt;
        um = v.um; uc = v.uc; ur = v.ur;
        exp_q.push_back(v);
        #2;
        e = exp_q.pop_front();
        checks++;
        if (hit !== e.eh || taken !== e.et || tgt !== e.etgt || mis !== e.emis) begin
            errors++;
            $display("FAIL %s: got hit=%b taken=%b target=%h mispred=%0d, expected hit=%b taken=%b target=%h mispred=%0d",
                     e.name, hit, taken, tgt, mis, e.eh, e.et, e.etgt, e.emis);
        end
    endtask

    task automatic reset_seq();
        apply(mk("rst_force0", 32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mis, 1'b0));
        apply(mk("rst_mis0", 32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0));
    endtask

    initial begin
        //          name          pc      uv upc      t  utgt     m  c  r  hit tk target   mis
        tbl.push_back(mk("post_reset",  32'h100, 0, 32'h0,   0, 32'h0,    0, 0, 0, 0, 0, 32'h0,   0));
        tbl.push_back(mk("alloc_pre",   32'h100, 1, 32'h100, 1, 32'h400,  1, 0, 0, 0, 0, 32'h0,   0));
        tbl.push_back(mk("same_cycle",  32'h100, 1, 32'h100, 0, 32'h0,    1, 0, 0, 1, 1, 32'h400, 1));
        tbl.push_back(mk("ctr1",        32'h100, 1, 32'h100, 0, 32'h0,    0, 0, 0, 1, 0, 32'h0,   2));
        tbl.push_back(mk("ctr0",        32'h100, 1, 32'h100, 0, 32'h0,    0, 0, 0, 1, 0, 32'h0,   2));
        tbl.push_back(mk("ctr0_sat",    32'h100, 1, 32'h100, 1, 32'h440,  0, 0, 0, 1, 0, 32'h0,   2));
        tbl.push_back(mk("ctr1_up",     32'h100, 1, 32'h100, 1, 32'h480,  0, 0, 0, 1, 0, 32'h0,   2));
        tbl.push_back(mk("ctr2_taken",  32'h100, 1, 32'h100, 1, 32'h480,  0, 0, 0, 1, 1, 32'h480, 2));
        tbl.push_back(mk("ctr3",        32'h100, 1, 32'h100, 1, 32'h480,  0, 0, 0, 1, 1, 32'h480, 2));
        tbl.push_back(mk("ctr3_sat",    32'h100, 1, 32'h100, 0, 32'hBAD0, 0, 0, 0, 1, 1, 32'h480, 2));
        tbl.push_back(mk("nt_keep_tgt", 32'h100, 0, 32'h0,   0, 32'h0,    0, 0, 0, 1, 1, 32'h480, 2));
        tbl.push_back(mk("alias_pre",   32'h100, 1, 32'h200, 1, 32'h800,  1, 0, 0, 1, 1, 32'h480, 2));
        tbl.push_back(mk("alias_old",   32'h100, 0, 32'h0,   0, 32'h0,    0, 0, 0, 0, 0, 32'h0,   3));
        tbl.push_back(mk("alias_new",   32'h200, 0, 32'h0,   0, 32'h0,    0, 0, 0, 1, 1, 32'h800, 3));
        tbl.push_back(mk("nt_miss_pre", 32'h104, 1, 32'h104, 0, 32'h900,  0, 0, 0, 0, 0, 32'h0,   3));
        tbl.push_back(mk("nt_no_alloc", 32'h104, 0, 32'h0,   0, 32'h0,    0, 0, 0, 0, 0, 32'h0,   3));
        tbl.push_back(mk("nt_alias",    32'h200, 1, 32'h300, 0, 32'h0,    0, 0, 0, 1, 1, 32'h800, 3));
        tbl.push_back(mk("alias_kept",  32'h200, 0, 32'h0,   0, 32'h0,    0, 0, 0, 1, 1, 32'h800, 3));
        tbl.push_back(mk("no_strobe",   32'h200, 0, 32'h200, 0, 32'h0,    1, 0, 0, 1, 1, 32'h800, 3));
        tbl.push_back(mk("no_strobe2",  32'h200, 0, 32'h0,   0, 32'h0,    0, 0, 0, 1, 1, 32'h800, 3));
        tbl.push_back(mk("top_idx_pre", 32'h1FC, 1, 32'h1FC, 1, 32'h1234, 0, 0, 0, 0, 0, 32'h0,   3));
        tbl.push_back(mk("top_idx",     32'h1FC, 0, 32'h0,   0, 32'h0,    0, 0, 0, 1, 1, 32'h1234, 3));
        tbl.push_back(mk("idx0_intact", 32'h200, 0, 32'h0,   0, 32'h0,    0, 0, 0, 1, 1, 32'h800, 3));
        // Reset mid-operation: outputs forced low, counter clears at the edge, update dropped.
        tbl.push_back(mk("rst_force",   32'h200, 1, 32'h104, 1, 32'h999,  1, 0, 0, 0, 0, 32'h0,   3, 1'b0));
        tbl.push_back(mk("rst_mis_clr", 32'h200, 0, 32'h0,   0, 32'h0,    0, 0, 0, 0, 0, 32'h0,   0, 1'b0));
        tbl.push_back(mk("rst_valid0",  32'h200, 0, 32'h0,   0, 32'h0,    0, 0, 0, 0, 0, 32'h0,   0));
        tbl.push_back(mk("rst_drop_up", 32'h104, 0, 32'h0,   0, 32'h0,    0, 0, 0, 0, 0, 32'h0,   0));
        tbl.push_back(mk("rst_valid63", 32'h1FC, 0, 32'h0,   0, 32'h0,    0, 0, 0, 0, 0, 32'h0,   0));

        rst = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Call/return sequence; without the RAS, calls and returns are plain BTB updates.
        apply(mk("call_100",   32'h300, 1, 32'h100, 1, 32'h900, 0, 1, 0, 0, 0, 32'h0,   0));
        apply(mk("ret_300",    32'h300, 1, 32'h300, 1, 32'h108, 0, 0, 1, 0, 0, 32'h0,   0));
        apply(mk("ret_lookup", 32'h300, 0, 32'h0,   0, 32'h0,   0, 0, 0, 1, 1, 32'h108, 0));
        apply(mk("call_104",   32'h300, 1, 32'h104, 1, 32'h900, 0, 1, 0, 1, 1, 32'h108, 0));
`ifdef BRANCH_PRED_RAS_EN
        apply(mk("ras_top",    32'h300, 1, 32'h300, 0, 32'h0,   0, 0, 0, 1, 1, 32'h10C, 0));
        apply(mk("ras_vs_ctr", 32'h300, 0, 32'h0,   0, 32'h0,   0, 0, 0, 1, 1, 32'h10C, 0));
`else
        apply(mk("no_ras_top", 32'h300, 1, 32'h300, 0, 32'h0,   0, 0, 0, 1, 1, 32'h108, 0));
        apply(mk("no_ras_ctr", 32'h300, 0, 32'h0,   0, 32'h0,   0, 0, 0, 1, 0, 32'h0,   0));
`endif

`ifdef BRANCH_PRED_RAS_EN
        reset_seq();
        apply(mk("m_ret_alloc", 32'h300, 1, 32'h300, 1, 32'h700, 0, 0, 1, 0, 0, 32'h0, 0));
        for (int k = 0; k < 5; k++)
            apply(mk($sformatf("m_call%0d", k), 32'h300, 1, 32'h1004 + 32'(4 * k), 1, 32'h2000,
                     0, 1, 0, 1, 1, k == 0 ? 32'h700 : 32'h1008 + 32'(4 * k), 0));
        apply(mk("m_full_top", 32'h300, 0, 32'h0, 0, 32'h0, 0, 0, 0, 1, 1, 32'h101C, 0));
        for (int k = 0; k < 4; k++)
            apply(mk($sformatf("m_pop%0d", k), 32'h300, 1, 32'h300, 1, 32'h700,
                     0, 0, 1, 1, 1, 32'h101C - 32'(4 * k), 0));
        apply(mk("m_lost_first", 32'h300, 0, 32'h0,   0, 32'h0,   0, 0, 0, 1, 1, 32'h700, 0));
        apply(mk("m_pop_empty",  32'h300, 1, 32'h300, 1, 32'h700, 0, 0, 1, 1, 1, 32'h700, 0));
        apply(mk("m_cr_empty",   32'h300, 1, 32'h300, 1, 32'h700, 0, 1, 1, 1, 1, 32'h700, 0));
        apply(mk("m_cr_full",    32'h300, 1, 32'h00C, 1, 32'h50,  0, 1, 1, 1, 1, 32'h308, 0));
        apply(mk("m_cr_top",     32'h300, 1, 32'h300, 1, 32'h700, 0, 0, 1, 1, 1, 32'h14,  0));
        apply(mk("m_cr_empty2",  32'h300, 0, 32'h0,   0, 32'h0,   0, 0, 0, 1, 1, 32'h700, 0));
        apply(mk("m_pre_rst1",   32'h300, 1, 32'h1004, 1, 32'h2000, 0, 1, 0, 1, 1, 32'h700, 0));
        apply(mk("m_pre_rst2",   32'h300, 1, 32'h1008, 1, 32'h2000, 0, 1, 0, 1, 1, 32'h100C, 0));
        reset_seq();
        apply(mk("m_post_rst",   32'h300, 1, 32'h300, 1, 32'h700, 0, 0, 1, 0, 0, 32'h0,   0));
        apply(mk("m_ras_clear",  32'h300, 0, 32'h0,   0, 32'h0,   0, 0, 0, 1, 1, 32'h700, 0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
